// File: rtl/lcd_update_arbiter_if.sv
// Handshake bundle between the update requesters, the LCD arbiter and the LCD driver.
// The arbiter uses the slave modport; the requester/driver side uses master.
interface lcd_update_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [6*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   req_drop;
  logic [2:0]        lcd_face;
  logic [2:0]        lcd_icon;
  logic              lcd_start;
  logic              lcd_done;
  logic              busy;
  logic              timeout_err;

  modport master (
    output req_valid, req_data, lcd_done,
    input  req_ack, req_drop, lcd_face, lcd_icon, lcd_start, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, lcd_done,
    output req_ack, req_drop, lcd_face, lcd_icon, lcd_start, busy, timeout_err
  );
endinterface

// File: rtl/lcd_update_arbiter.sv
// Round-robin arbiter sharing the pet LCD driver among NREQ update requesters.
// Define LCD_ARB_COALESCE_EN to let a repeated request overwrite its pending payload instead of dropping it.
module lcd_update_arbiter #(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input logic                 clk,
  input logic                 rst,
  lcd_update_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, START, BUSY, ACK} state_t;

  state_t          state;
  logic [NREQ-1:0] pend;
  logic [5:0]      pay [NREQ];
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   cur;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   winner;
  logic            found;
  logic [NREQ-1:0] clr;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] drop_q;
  logic [2:0]      face_q;
  logic [2:0]      icon_q;
  logic            start_q;
  logic            busy_q;
  logic            to_q;

  // First pending requester strictly after the previous grant, wrapping around.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && pend[GW'(idx)]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  assign clr = (state == IDLE && found) ? (NREQ'(1) << winner) : '0;

  // A request landing on its own grant-clear edge is a fresh capture, never a drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend   <= '0;
      drop_q <= '0;
      for (int i = 0; i < NREQ; i++) pay[i] <= '0;
    end else begin
      pend <= (pend & ~clr) | bus.req_valid;
`ifdef LCD_ARB_COALESCE_EN
      drop_q <= '0;
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i]) pay[i] <= bus.req_data[6*i +: 6];
`else
      drop_q <= bus.req_valid & pend & ~clr;
      for (int i = 0; i < NREQ; i++)
        if (bus.req_valid[i] && (clr[i] || !pend[i])) pay[i] <= bus.req_data[6*i +: 6];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= GW'(NREQ - 1);
      cur         <= '0;
      timer       <= '0;
      face_q      <= '0;
      icon_q      <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      to_q        <= 1'b0;
      ack_q       <= '0;
    end else begin
      start_q <= 1'b0;
      to_q    <= 1'b0;
      ack_q   <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            face_q  <= pay[winner][5:3];
            icon_q  <= pay[winner][2:0];
            cur     <= winner;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (timer != '1) timer <= timer + 1'b1;
          // Done on the expiry cycle still wins over the timeout.
          if (bus.lcd_done) begin
            ack_q <= NREQ'(1) << cur;
            state <= ACK;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            to_q  <= 1'b1;
            ack_q <= NREQ'(1) << cur;
            state <= ACK;
          end
        end
        ACK: begin
          last_grant <= cur;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.req_drop    = drop_q;
  assign bus.lcd_face    = face_q;
  assign bus.lcd_icon    = icon_q;
  assign bus.lcd_start   = start_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_lcd_update_arbiter.sv
// Scoreboard bench for lcd_update_arbiter: expected grants are queued as requests are driven
// and compared when the arbiter starts and acknowledges each redraw.
module tb_lcd_update_arbiter;
  localparam int NREQ = 3;
  localparam int TOC  = 16;

  typedef struct packed {
    logic [1:0] idx;
    logic [2:0] face;
    logic [2:0] icon;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  lcd_update_arbiter_if #(.NREQ(NREQ)) bus ();

  lcd_update_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TOC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drive_req(input logic [NREQ-1:0] v, input logic [6*NREQ-1:0] d);
    bus.req_valid = v;
    bus.req_data  = d;
    tick();
    bus.req_valid = '0;
  endtask

  // Waits for lcd_start, optionally pulses lcd_done d cycles later, returns what the DUT showed.
  task automatic serve_one(input int d, input bit give_done, output bit started,
                           output logic [2:0] face, output logic [2:0] icon,
                           output logic [NREQ-1:0] ack, output logic to, output int lat);
    int n;
    started = 1'b0; face = '0; icon = '0; ack = '0; to = 1'b0; lat = 0; n = 0;
    while (bus.lcd_start !== 1'b1 && n < 60) begin tick(); n++; end
    if (bus.lcd_start !== 1'b1) return;
    started = 1'b1;
    face = bus.lcd_face;
    icon = bus.lcd_icon;
    if (give_done) begin
      repeat (d) begin tick(); lat++; end
      bus.lcd_done = 1'b1;
      tick(); lat++;
      bus.lcd_done = 1'b0;
    end else begin
      tick(); lat++;
    end
    while (bus.req_ack === '0 && lat < 60) begin tick(); lat++; end
    ack = bus.req_ack;
    to  = bus.timeout_err;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.lcd_done  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.lcd_face, bus.lcd_icon} !== 6'd0) begin
      errors++; $display("[TB] FAIL reset_face_icon: got %0h want 0", {bus.lcd_face, bus.lcd_icon});
    end
    checks++;
    if ({bus.lcd_start, bus.busy, bus.timeout_err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b want 000", {bus.lcd_start, bus.busy, bus.timeout_err});
    end
    checks++;
    if ({bus.req_ack, bus.req_drop} !== '0) begin
      errors++; $display("[TB] FAIL reset_ack_drop: got %b want 0", {bus.req_ack, bus.req_drop});
    end
    rst = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_single();
    bit started; logic [2:0] f, ic; logic [NREQ-1:0] a; logic t; int lat; exp_t e;
    exp_q.push_back(exp_t'{idx: 2'd0, face: 3'd1, icon: 3'd2, to: 1'b0});
    drive_req(3'b001, {12'h0, 3'd1, 3'd2});
    checks++;
    if (bus.lcd_start !== 1'b0) begin
      errors++; $display("[TB] FAIL single_start_early: got %b want 0", bus.lcd_start);
    end
    tick();
    checks++;
    if ({bus.lcd_start, bus.busy} !== 2'b11) begin
      errors++; $display("[TB] FAIL single_start_k2: got %b want 11", {bus.lcd_start, bus.busy});
    end
    serve_one(8, 1'b1, started, f, ic, a, t, lat);
    e = exp_q.pop_front();
    checks++;
    if ({started, f, ic, a, t} !== {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to}) begin
      errors++; $display("[TB] FAIL single_grant: got %b want %b", {started, f, ic, a, t},
                         {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to});
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("[TB] FAIL single_ack_latency: got %0d want 9", lat);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_busy_clear: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    bit started; logic [2:0] f, ic; logic [NREQ-1:0] a; logic t; int lat; exp_t e;
    do_reset();
    exp_q.push_back(exp_t'{idx: 2'd0, face: 3'd1, icon: 3'd1, to: 1'b0});
    exp_q.push_back(exp_t'{idx: 2'd1, face: 3'd2, icon: 3'd2, to: 1'b0});
    exp_q.push_back(exp_t'{idx: 2'd2, face: 3'd3, icon: 3'd3, to: 1'b0});
    drive_req(3'b111, {6'o33, 6'o22, 6'o11});
    exp_q.push_back(exp_t'{idx: 2'd0, face: 3'd4, icon: 3'd5, to: 1'b0});
    exp_q.push_back(exp_t'{idx: 2'd2, face: 3'd6, icon: 3'd7, to: 1'b0});
    for (int j = 0; j < 5; j++) begin
      if (j == 3) drive_req(3'b101, {6'o67, 6'o00, 6'o45});
      serve_one(3, 1'b1, started, f, ic, a, t, lat);
      e = exp_q.pop_front();
      checks++;
      if ({started, f, ic, a, t} !== {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to}) begin
        errors++; $display("[TB] FAIL rr_grant_%0d: got %b want %b", j, {started, f, ic, a, t},
                           {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to});
      end
    end
  endtask

  task automatic test_timeout();
    bit started; logic [2:0] f, ic; logic [NREQ-1:0] a; logic t; int lat; exp_t e;
    exp_q.push_back(exp_t'{idx: 2'd0, face: 3'd5, icon: 3'd1, to: 1'b1});
    exp_q.push_back(exp_t'{idx: 2'd1, face: 3'd2, icon: 3'd6, to: 1'b0});
    drive_req(3'b011, {6'o00, 6'o26, 6'o51});
    for (int j = 0; j < 2; j++) begin
      serve_one(TOC, j == 1, started, f, ic, a, t, lat);
      e = exp_q.pop_front();
      checks++;
      if ({started, f, ic, a, t} !== {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to}) begin
        errors++; $display("[TB] FAIL timeout_grant_%0d: got %b want %b", j, {started, f, ic, a, t},
                           {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to});
      end
      checks++;
      if (lat !== TOC + 1) begin
        errors++; $display("[TB] FAIL timeout_latency_%0d: got %0d want %0d", j, lat, TOC + 1);
      end
    end
  endtask

  task automatic test_collision();
    bit started; logic [2:0] f, ic; logic [NREQ-1:0] a; logic t; int lat; int n; exp_t e;
    exp_q.push_back(exp_t'{idx: 2'd0, face: 3'd1, icon: 3'd3, to: 1'b0});
    drive_req(3'b001, {12'h0, 6'o13});
    n = 0;
    while (bus.lcd_start !== 1'b1 && n < 20) begin tick(); n++; end
    e = exp_q.pop_front();
    checks++;
    if ({bus.lcd_start, bus.lcd_face, bus.lcd_icon} !== {1'b1, e.face, e.icon}) begin
      errors++; $display("[TB] FAIL coll_first_grant: got %b want %b",
                         {bus.lcd_start, bus.lcd_face, bus.lcd_icon}, {1'b1, e.face, e.icon});
    end
    tick();
    drive_req(3'b010, {6'h00, 6'h05, 6'h00});
    checks++;
    if (bus.req_drop !== 3'b000) begin
      errors++; $display("[TB] FAIL coll_first_capture_drop: got %b want 000", bus.req_drop);
    end
    drive_req(3'b010, {6'h00, 6'h0A, 6'h00});
    checks++;
`ifdef LCD_ARB_COALESCE_EN
    if (bus.req_drop !== 3'b000) begin
      errors++; $display("[TB] FAIL coll_second_drop: got %b want 000", bus.req_drop);
    end
    exp_q.push_back(exp_t'{idx: 2'd1, face: 3'd1, icon: 3'd2, to: 1'b0});
`else
    if (bus.req_drop !== 3'b010) begin
      errors++; $display("[TB] FAIL coll_second_drop: got %b want 010", bus.req_drop);
    end
    exp_q.push_back(exp_t'{idx: 2'd1, face: 3'd0, icon: 3'd5, to: 1'b0});
`endif
    bus.lcd_done = 1'b1;
    tick();
    bus.lcd_done = 1'b0;
    checks++;
    if ({bus.req_ack, bus.req_drop} !== {3'b001, 3'b000}) begin
      errors++; $display("[TB] FAIL coll_first_ack: got %b want 001000", {bus.req_ack, bus.req_drop});
    end
    serve_one(2, 1'b1, started, f, ic, a, t, lat);
    e = exp_q.pop_front();
    checks++;
    if ({started, f, ic, a, t} !== {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to}) begin
      errors++; $display("[TB] FAIL coll_payload: got %b want %b", {started, f, ic, a, t},
                         {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to});
    end
  endtask

  task automatic test_grant_edge();
    bit started; logic [2:0] f, ic; logic [NREQ-1:0] a; logic t; int lat; exp_t e;
    tick();
    exp_q.push_back(exp_t'{idx: 2'd1, face: 3'd2, icon: 3'd3, to: 1'b0});
    exp_q.push_back(exp_t'{idx: 2'd1, face: 3'd4, icon: 3'd4, to: 1'b0});
    drive_req(3'b010, {6'o00, 6'o23, 6'o00});
    drive_req(3'b010, {6'o00, 6'o44, 6'o00});
    checks++;
    if ({bus.lcd_start, bus.req_drop} !== {1'b1, 3'b000}) begin
      errors++; $display("[TB] FAIL edge_no_drop: got %b want 1000", {bus.lcd_start, bus.req_drop});
    end
    for (int j = 0; j < 2; j++) begin
      serve_one(2, 1'b1, started, f, ic, a, t, lat);
      e = exp_q.pop_front();
      checks++;
      if ({started, f, ic, a, t} !== {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to}) begin
        errors++; $display("[TB] FAIL edge_grant_%0d: got %b want %b", j, {started, f, ic, a, t},
                           {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to});
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    bit started; logic [2:0] f, ic; logic [NREQ-1:0] a; logic t; int lat; int n; exp_t e;
    logic seen;
    tick();
    drive_req(3'b001, {12'h0, 6'o77});
    n = 0;
    while (bus.lcd_start !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    drive_req(3'b110, {6'o12, 6'o34, 6'o00});
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++;
    if ({bus.busy, bus.lcd_face, bus.lcd_icon} !== 7'd0) begin
      errors++; $display("[TB] FAIL midreset_state: got %b want 0", {bus.busy, bus.lcd_face, bus.lcd_icon});
    end
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.req_ack !== '0 || bus.lcd_start !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_no_activity: got %b want 0", seen);
    end
    exp_q.push_back(exp_t'{idx: 2'd2, face: 3'd7, icon: 3'd6, to: 1'b0});
    drive_req(3'b100, {6'o76, 12'h0});
    serve_one(1, 1'b1, started, f, ic, a, t, lat);
    e = exp_q.pop_front();
    checks++;
    if ({started, f, ic, a, t} !== {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to}) begin
      errors++; $display("[TB] FAIL midreset_req2: got %b want %b", {started, f, ic, a, t},
                         {1'b1, e.face, e.icon, NREQ'(1) << e.idx, e.to});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_collision();
    test_grant_edge();
    test_reset_mid_busy();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("[TB] FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
